i2c_byte_engine: RTL and testbench

Parametrised I2C master byte engine for both directions: transmits DATA_W bits and checks the slave ACK, or receives DATA_W bits and returns master ACK/NACK. Adds bit order selection and a clock-stretch timeout. Sits between the I2C command sequencer (start/stop/address logic) and the open-drain pad muxing. All bit timing is advanced by a quarter-bit i_tick strobe from the shared prescaler.

---
 rtl/i2c_pkg.sv | 14 +
 rtl/i2c_stretch_timer.sv | 19 +
 rtl/i2c_byte_engine.sv | 110 +++++++++++
 tb/tb_i2c_byte_engine.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared phase/state encodings and bus constants for the I2C byte engine
package i2c_pkg;
  localparam logic [1:0] P0 = 2'd0;
  localparam logic [1:0] P1 = 2'd1;
  localparam logic [1:0] P2 = 2'd2;
  localparam logic [1:0] P3 = 2'd3;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;
endpackage

// File: rtl/i2c_stretch_timer.sv
// i2c_stretch_timer: counts stalled SCL-high ticks and flags when the limit is reached
module i2c_stretch_timer #(
  parameter int STRETCH_MAX = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);
  localparam int CW = STRETCH_MAX > 0 ? $clog2(STRETCH_MAX + 1) : 1;
  logic [CW-1:0] cnt;
  // clear wins over increment so a fresh start or a released SCL restarts the count
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (inc) cnt <= cnt + 1'b1;
  end
  assign expired = (STRETCH_MAX != 0) && (cnt == CW'(STRETCH_MAX));
endmodule

// File: rtl/i2c_byte_engine.sv
// i2c_byte_engine: I2C master byte engine with ACK handling, bit order and stretch timeout
module i2c_byte_engine
  import i2c_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int STRETCH_MAX = 255,
  parameter int MSB_FIRST   = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_tick,
  input  logic              i_start,
  input  logic              i_rw,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_rx_nack,
  input  logic              i_scl,
  input  logic              i_sda,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_nack_err,
  output logic              o_timeout_err,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_sda,
  output logic              o_scl,
  output logic              o_sda_disable,
  output logic              o_scl_disable
);
  localparam int CW = DATA_W > 1 ? $clog2(DATA_W) : 1;
  logic [1:0]        state, phase;
  logic [CW-1:0]     slot;
  logic              rw, rx_nack, ack_bit, clr, inc, expired;
  logic [DATA_W-1:0] tx, rx;

  function automatic logic [CW-1:0] idx(input logic [CW-1:0] k);
    return (MSB_FIRST != 0) ? CW'(DATA_W - 1) - k : k;
  endfunction

  assign o_busy        = state != ST_IDLE;
  assign o_scl_disable = o_busy && (phase == P1 || phase == P2);
  assign o_sda_disable = (state == ST_DATA && rw == RW_READ) || (state == ST_ACK && rw == RW_WRITE);
  assign clr = (state == ST_IDLE && i_start) || (o_busy && phase == P1 && i_tick && i_scl);
  assign inc = o_busy && phase == P1 && i_tick && !i_scl;

  i2c_stretch_timer #(.STRETCH_MAX(STRETCH_MAX)) u_timer (
    .clk(i_clk), .rst(i_rst), .clr(clr), .inc(inc), .expired(expired)
  );

  // slot/phase sequencer: latches the request, walks P0..P3 per slot, samples on P2
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
      phase <= P0;
      slot <= '0;
      rw <= RW_WRITE;
      rx_nack <= NACK;
      ack_bit <= ACK;
      tx <= '0;
      rx <= '0;
      o_done <= 1'b0;
      o_nack_err <= 1'b0;
      o_timeout_err <= 1'b0;
      o_rx_data <= '0;
      o_sda <= 1'b1;
      o_scl <= 1'b0;
    end else begin
      o_done <= 1'b0;
      o_timeout_err <= 1'b0;
      if (state == ST_IDLE) begin
        if (i_start) begin
          rw <= i_rw;
          tx <= i_tx_data;
          rx_nack <= i_rx_nack;
          o_nack_err <= 1'b0;
          o_sda <= i_rw == RW_READ ? 1'b1 : i_tx_data[idx('0)];
          slot <= '0;
          phase <= P0;
          state <= ST_DATA;
        end
      end else if (phase == P1 && expired) begin
        state <= ST_IDLE;
        o_timeout_err <= 1'b1;
        o_scl <= 1'b0;
        o_sda <= 1'b1;
      end else if (i_tick) begin
        phase <= (phase == P1 && !i_scl) ? phase : phase + 2'd1;
        if (phase == P0) o_scl <= 1'b1;
        if (phase == P2) begin
          o_scl <= 1'b0;
          ack_bit <= i_sda;
          if (state == ST_DATA) rx[idx(slot)] <= i_sda;
        end
        if (phase == P3) begin
          if (state == ST_ACK) begin
            state <= ST_IDLE;
            o_done <= 1'b1;
            o_sda <= 1'b1;
            o_nack_err <= rw == RW_WRITE && ack_bit == NACK;
            if (rw == RW_READ) o_rx_data <= rx;
          end else if (slot == CW'(DATA_W - 1)) begin
            state <= ST_ACK;
            o_sda <= rw == RW_READ ? rx_nack : 1'b1;
          end else begin
            slot <= slot + 1'b1;
            o_sda <= rw == RW_READ ? 1'b1 : tx[idx(slot + 1'b1)];
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_i2c_byte_engine.sv
// tb_i2c_byte_engine: directed table-driven bench for the I2C byte engine
module tb_i2c_byte_engine;
  logic clk = 0, rst = 1, tick = 0, start = 0, start_b = 0, rw = 0, rx_nack = 0, scl = 1, sda = 1;
  logic [7:0] tx = 0;
  logic a_busy, a_done, a_nack, a_to, a_sda, a_scl, a_sda_dis, a_scl_dis;
  logic b_busy, b_done, b_nack, b_to, b_sda, b_scl, b_sda_dis, b_scl_dis;
  logic [7:0] a_rx, b_rx;
  int tests = 0, failed = 0;

  typedef struct {
    logic rw; logic [7:0] tx; logic rx_nack; logic [7:0] line; logic ack_line; logic exp_nack; logic [7:0] exp_rx;
  } vec_t;
  vec_t vecs[5];

  always #5 clk = ~clk;

  i2c_byte_engine #(.DATA_W(8), .STRETCH_MAX(4), .MSB_FIRST(1)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_start(start), .i_rw(rw), .i_tx_data(tx),
    .i_rx_nack(rx_nack), .i_scl(scl), .i_sda(sda), .o_busy(a_busy), .o_done(a_done),
    .o_nack_err(a_nack), .o_timeout_err(a_to), .o_rx_data(a_rx), .o_sda(a_sda), .o_scl(a_scl),
    .o_sda_disable(a_sda_dis), .o_scl_disable(a_scl_dis));

  i2c_byte_engine #(.DATA_W(8), .STRETCH_MAX(255), .MSB_FIRST(0)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_start(start_b), .i_rw(rw), .i_tx_data(tx),
    .i_rx_nack(rx_nack), .i_scl(scl), .i_sda(sda), .o_busy(b_busy), .o_done(b_done),
    .o_nack_err(b_nack), .o_timeout_err(b_to), .o_rx_data(b_rx), .o_sda(b_sda), .o_scl(b_scl),
    .o_sda_disable(b_sda_dis), .o_scl_disable(b_scl_dis));

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_tick();
    @(negedge clk);
    tick = 1;
    @(negedge clk);
    tick = 0;
  endtask

  task automatic start_write(input logic [7:0] d);
    @(negedge clk);
    rw = 0; tx = d; start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic xfer(input vec_t v);
    logic ed, es;
    @(negedge clk);
    rw = v.rw; tx = v.tx; rx_nack = v.rx_nack; start = 1; tick = 1;
    @(negedge clk);
    start = 0; tick = 0; rw = ~v.rw; tx = ~v.tx; rx_nack = ~v.rx_nack;
    chk("busy_after_start", a_busy, 1);
    chk("nack_cleared_on_start", a_nack, 0);
    for (int s = 0; s < 9; s++) begin
      ed = s < 8 ? v.rw : !v.rw;
      es = s < 8 ? (v.rw ? 1'b1 : v.tx[7-s]) : v.rx_nack;
      do_tick();
      chk("scl_p1", a_scl, 1);
      chk("scl_dis_p1", a_scl_dis, 1);
      chk("sda_dis", a_sda_dis, ed);
      if (!ed) chk("sda_bit", a_sda, es);
      sda = s < 8 ? (v.rw ? v.line[7-s] : 1'b1) : (v.rw ? 1'b1 : v.ack_line);
      do_tick();
      do_tick();
      chk("scl_p3", a_scl, 0);
      chk("scl_dis_p3", a_scl_dis, 0);
      do_tick();
      chk("done_timing", a_done, s == 8);
    end
    sda = 1;
    chk("nack_err", a_nack, v.exp_nack);
    chk("rx_data", a_rx, v.exp_rx);
    @(negedge clk);
    chk("done_one_cycle", a_done, 0);
    chk("idle_busy", a_busy, 0);
    repeat (3) @(negedge clk);
    chk("nack_held", a_nack, v.exp_nack);
  endtask

  initial begin
    vecs[0] = '{1'b0, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
    vecs[1] = '{1'b0, 8'h3C, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00};
    vecs[2] = '{1'b1, 8'h00, 1'b1, 8'h5A, 1'b1, 1'b0, 8'h5A};
    vecs[3] = '{1'b1, 8'h00, 1'b0, 8'hC3, 1'b1, 1'b0, 8'hC3};
    vecs[4] = '{1'b0, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 8'hC3};
    repeat (3) @(negedge clk);
    chk("rst_busy", a_busy, 0);
    chk("rst_sda", a_sda, 1);
    chk("rst_scl", a_scl, 0);
    chk("rst_dis", {a_sda_dis, a_scl_dis}, 0);
    chk("rst_rx", a_rx, 0);
    rst = 0;
    for (int i = 0; i < 5; i++) xfer(vecs[i]);

    // LSB-first read: first wire bit lands in bit 0
    @(negedge clk);
    rw = 1; rx_nack = 0; start_b = 1;
    @(negedge clk);
    start_b = 0;
    for (int s = 0; s < 9; s++) begin
      do_tick();
      sda = (s == 0 || s == 8);
      do_tick();
      do_tick();
      do_tick();
    end
    sda = 1;
    chk("lsb_done", b_done, 1);
    chk("lsb_rx", b_rx, 8'h01);

    // clock stretch timeout in slot 3 P1
    start_write(8'h00);
    repeat (8) do_tick();
    do_tick();
    scl = 0;
    repeat (3) do_tick();
    chk("to_not_yet", a_to, 0);
    chk("to_busy_stalled", a_busy, 1);
    do_tick();
    @(negedge clk);
    chk("to_pulse", a_to, 1);
    chk("to_idle", a_busy, 0);
    chk("to_no_done", a_done, 0);
    chk("to_scl_low", a_scl, 0);
    @(negedge clk);
    chk("to_one_cycle", a_to, 0);
    scl = 1;

    // reset mid slot 5 with an ignored start while busy
    start_write(8'h96);
    repeat (16) do_tick();
    do_tick();
    @(negedge clk);
    start = 1; rw = 1; tx = 8'hFF;
    @(negedge clk);
    start = 0;
    chk("busy_start_ignored_dis", a_sda_dis, 0);
    chk("busy_start_ignored_sda", a_sda, 0);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("mid_rst_busy", a_busy, 0);
    chk("mid_rst_pulses", {a_done, a_to, a_nack}, 0);
    chk("mid_rst_rx", a_rx, 0);
    chk("mid_rst_lines", {a_sda, a_scl, a_sda_dis, a_scl_dis}, 4'b1000);
    repeat (4) do_tick();
    chk("post_rst_idle", a_busy, 0);
    chk("post_rst_no_done", a_done, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
